dram_req_arbiter: RTL and testbench
===================================

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter U_ADDR_WIDTH, default 12: controller address width, <bank,row,col>.
REQ-003 SHALL have parameter U_DATA_WIDTH, default 8: user data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit, cycles.
REQ-005 SHALL have port u_clk  in  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port u_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req  in  NUM_REQ  per-requester request level, held until its done.
REQ-008 SHALL have port req_cmd  in  NUM_REQ  per-requester command: 1=write, 0=read.
REQ-009 SHALL have port req_addr  in  NUM_REQ*U_ADDR_WIDTH  packed addresses; requester i in slice i.
REQ-010 SHALL have port req_wdata  in  NUM_REQ*U_DATA_WIDTH  packed write data.
REQ-011 SHALL have port gnt  out  NUM_REQ  one-hot grant, high from grant until done.
REQ-012 SHALL have port done  out  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-013 SHALL have port rd_data  out  U_DATA_WIDTH  read data, valid only with done of a read.
REQ-014 SHALL have port u_en  out  1  controller enable.
REQ-015 SHALL have ports u_addr/u_data_i/u_cmd  out  U_ADDR_WIDTH/U_DATA_WIDTH/1  muxed fields of granted requester.
REQ-016 SHALL have ports u_busy/u_cmd_ack/u_data_valid  in  1 each  controller status.
REQ-017 SHALL have port u_data_o  in  U_DATA_WIDTH  controller read data.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> ACCEPTED -> (WAIT_BUSY_LOW | WAIT_RDATA) -> IDLE.
REQ-019 IDLE: when u_busy=0 and any req, SHALL register round-robin winner into gnt, move to ISSUE next cycle; when u_busy=1 (e.g. refresh), SHALL not grant.
REQ-020 Round-robin: search starts at index last_granted+1 mod NUM_REQ; pointer updates only on done; reset pointer = NUM_REQ-1 (requester 0 wins first).
REQ-021 ISSUE: u_en=1, u_addr/u_data_i/u_cmd driven from registered copy of granted requester's fields, stable until done; leave on u_cmd_ack=1 to ACCEPTED.
REQ-022 ACCEPTED: u_en=1; on u_busy=1 go to WAIT_BUSY_LOW (write) or WAIT_RDATA (read).
REQ-023 WAIT_BUSY_LOW: u_en=1; on u_busy=0 pulse done[g], clear gnt, u_en=0 same cycle, go IDLE.
REQ-024 WAIT_RDATA: u_en=1; on u_data_valid=1 capture u_data_o into rd_data, pulse done[g] next cycle, go IDLE.
REQ-025 Simultaneous req from all requesters SHALL be served strictly in rotation; no requester waits more than NUM_REQ-1 transactions.
REQ-026 Dropping req[g] mid-transaction SHALL be ignored; transaction completes, done still pulses.
REQ-027 u_data_valid outside WAIT_RDATA SHALL be ignored; rd_data holds last value.

Reset
REQ-028 On u_rst: state=IDLE, gnt=0, done=0, u_en=0, u_addr=0, u_data_i=0, u_cmd=0, rd_data=0, pointer=NUM_REQ-1, watchdog=0; effective immediately, mid-transaction included.

Configuration
REQ-029 Macro DRAM_ARB_TIMEOUT_EN defined: watchdog counts cycles in any non-IDLE state; at TIMEOUT_CYCLES SHALL force done[g] pulse, assert output err (1 bit) for that cycle, u_en=0, go IDLE, advance pointer.
REQ-030 Macro undefined: no watchdog, no err port; FSM waits indefinitely.

Structure
REQ-031 Package dram_arb_pkg SHALL hold FSM state enum, CMD_READ/CMD_WRITE constants.
REQ-032 Sub-module dram_rr_picker (combinational: req vector + pointer -> one-hot winner) SHALL be used.

Verification
REQ-033 Single write: req[0]=1, cmd=1, addr=0x2A5, wdata=0x5C -> u_addr=0x2A5, u_data_i=0x5C, u_cmd=1 on u_cmd_ack; done[0] on u_busy fall.
REQ-034 Read: req[2], cmd=0; model returns u_data_o=0xC3 with u_data_valid -> next cycle done[2]=1, rd_data=0xC3.
REQ-035 All four req held -> grant order 0,1,2,3,0; each done exactly once per transaction.
REQ-036 u_busy=1 (refresh) for 20 cycles while req[1]=1 -> gnt stays 0 until u_busy=0, then gnt=0b0010.
REQ-037 u_rst asserted in WAIT_RDATA -> all outputs zero same cycle; after release req[0] granted first.
REQ-038 With DRAM_ARB_TIMEOUT_EN, u_cmd_ack never asserted -> after 64 cycles done[g]=1, err=1, u_en=0.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg -- shared definitions for the DRAM request arbiter.
//   arb_state_t : arbiter FSM states
//   CMD_READ / CMD_WRITE : encoding of the per-requester command bit
package dram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_ISSUE         = 3'd1,
    ST_ACCEPTED      = 3'd2,
    ST_WAIT_BUSY_LOW = 3'd3,
    ST_WAIT_RDATA    = 3'd4
  } arb_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/dram_rr_picker.sv
// dram_rr_picker -- combinational round-robin winner selection.
// Ports:
//   req    in  NUM_REQ  eligible request vector
//   ptr    in  PTR_W    index of the last served requester
//   winner out NUM_REQ  one-hot winner (all zero when no request)
// The search starts at ptr+1 and wraps, so the last served requester has
// the lowest priority.
module dram_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

  logic found;

  // Outer loop walks the rotation order, inner loop finds the requester at
  // that rotation distance; only constant bit indices are used.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter -- round-robin arbiter sharing one DRAM controller user
// port between NUM_REQ requesters.
// Ports:
//   u_clk, u_rst                 clock, asynchronous active-high reset
//   req/req_cmd                  per-requester request level and command
//   req_addr/req_wdata           packed per-requester address / write data
//   gnt, done                    one-hot grant, one-cycle completion pulse
//   rd_data                      read data, valid with done of a read
//   u_en/u_addr/u_data_i/u_cmd   request to the controller
//   u_busy/u_cmd_ack/u_data_valid/u_data_o  controller status and read data
//   err (only with DRAM_ARB_TIMEOUT_EN)     watchdog abort flag
// Build option: define DRAM_ARB_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT_CYCLES non-idle cycles.
module dram_req_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int U_ADDR_WIDTH   = 12,
  parameter int U_DATA_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             u_clk,
  input  logic                             u_rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_cmd,
  input  logic [NUM_REQ*U_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*U_DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [U_DATA_WIDTH-1:0]          rd_data,
  output logic                             u_en,
  output logic [U_ADDR_WIDTH-1:0]          u_addr,
  output logic [U_DATA_WIDTH-1:0]          u_data_i,
  output logic                             u_cmd,
  input  logic                             u_busy,
  input  logic                             u_cmd_ack,
  input  logic                             u_data_valid,
  input  logic [U_DATA_WIDTH-1:0]          u_data_o
`ifdef DRAM_ARB_TIMEOUT_EN
  ,
  output logic                             err
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]       gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]       done_reg, done_next;
  logic [PTR_W-1:0]         gidx_reg, gidx_next;
  logic [PTR_W-1:0]         ptr_reg, ptr_next;
  logic [U_ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [U_DATA_WIDTH-1:0]  wdata_reg, wdata_next;
  logic                     cmd_reg, cmd_next;
  logic [U_DATA_WIDTH-1:0]  rd_data_reg, rd_data_next;
  logic                     finish;

  logic [NUM_REQ-1:0]       req_eligible;
  logic [NUM_REQ-1:0]       winner;
  logic [PTR_W-1:0]         win_idx;

  logic [U_ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [U_DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*U_ADDR_WIDTH +: U_ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*U_DATA_WIDTH +: U_DATA_WIDTH];
    end
  endgenerate

  // A requester sees its done one cycle late and may still hold req in the
  // done cycle; excluding it then avoids re-granting a finished request.
  assign req_eligible = req & ~done_reg;

  dram_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req_eligible),
    .ptr    (ptr_reg),
    .winner (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wdog_reg, wdog_next;
  logic            err_reg, err_next;
`else
  // Watchdog is compiled out; keep the parameter referenced.
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;
    gidx_next    = gidx_reg;
    ptr_next     = ptr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cmd_next     = cmd_reg;
    rd_data_next = rd_data_reg;
    finish       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!u_busy && (|req_eligible)) begin
          gnt_next   = winner;
          gidx_next  = win_idx;
          addr_next  = addr_arr[win_idx];
          wdata_next = wdata_arr[win_idx];
          cmd_next   = req_cmd[win_idx];
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (u_cmd_ack) state_next = ST_ACCEPTED;
      end
      ST_ACCEPTED: begin
        if (u_busy) begin
          state_next = (cmd_reg == CMD_WRITE) ? ST_WAIT_BUSY_LOW : ST_WAIT_RDATA;
        end
      end
      ST_WAIT_BUSY_LOW: begin
        if (!u_busy) finish = 1'b1;
      end
      ST_WAIT_RDATA: begin
        if (u_data_valid) begin
          rd_data_next = u_data_o;
          finish       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (finish) begin
      done_next  = gnt_reg;
      gnt_next   = '0;
      ptr_next   = gidx_reg;
      state_next = ST_IDLE;
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    err_next = 1'b0;
    // A normal completion in the same cycle wins over the abort.
    if (state_reg != ST_IDLE && !finish &&
        wdog_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
      done_next  = gnt_reg;
      err_next   = 1'b1;
      gnt_next   = '0;
      ptr_next   = gidx_reg;
      state_next = ST_IDLE;
    end
    if (state_reg == ST_IDLE || state_next == ST_IDLE) wdog_next = '0;
    else wdog_next = wdog_reg + WD_W'(1);
`endif
  end

  always_ff @(posedge u_clk or posedge u_rst) begin
    if (u_rst) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      done_reg    <= '0;
      gidx_reg    <= '0;
      ptr_reg     <= PTR_W'(NUM_REQ - 1);
      addr_reg    <= '0;
      wdata_reg   <= '0;
      cmd_reg     <= CMD_READ;
      rd_data_reg <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
      wdog_reg    <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      gidx_reg    <= gidx_next;
      ptr_reg     <= ptr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      cmd_reg     <= cmd_next;
      rd_data_reg <= rd_data_next;
`ifdef DRAM_ARB_TIMEOUT_EN
      wdog_reg    <= wdog_next;
      err_reg     <= err_next;
`endif
    end
  end

  // u_en follows the state directly so it drops in the done cycle and
  // immediately on reset.
  assign u_en     = (state_reg != ST_IDLE);
  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign rd_data  = rd_data_reg;
  assign u_addr   = addr_reg;
  assign u_data_i = wdata_reg;
  assign u_cmd    = cmd_reg;
`ifdef DRAM_ARB_TIMEOUT_EN
  assign err      = err_reg;
`endif

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter -- directed bench for dram_req_arbiter with a
// transaction-level reference model checked every cycle.
// Build option: DRAM_ARB_TIMEOUT_EN selects the watchdog scenario.
module tb_dram_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 64;
`ifdef DRAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              u_clk = 1'b0;
  logic              u_rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_cmd = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     gnt, done;
  logic [DW-1:0]     rd_data;
  logic              u_en;
  logic [AW-1:0]     u_addr;
  logic [DW-1:0]     u_data_i;
  logic              u_cmd;
  logic              u_busy = 1'b0;
  logic              u_cmd_ack = 1'b0;
  logic              u_data_valid = 1'b0;
  logic [DW-1:0]     u_data_o = '0;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 u_clk = ~u_clk;

  dram_req_arbiter #(
    .NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .u_clk(u_clk), .u_rst(u_rst), .req(req), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rd_data(rd_data), .u_en(u_en), .u_addr(u_addr), .u_data_i(u_data_i),
    .u_cmd(u_cmd), .u_busy(u_busy), .u_cmd_ack(u_cmd_ack),
    .u_data_valid(u_data_valid), .u_data_o(u_data_o)
`ifdef DRAM_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

`ifndef DRAM_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time: grant goes to the first requester after the
  // last served one; the transaction then needs ack, busy rise, and either
  // busy fall (write) or read data, and done follows one cycle later.
  function automatic int pick(input logic [NR-1:0] elig, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (elig[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  bit            m_active = 1'b0;
  int            m_g = 0;
  int            m_last = NR - 1;
  int            m_ph = 0;   // 0 need ack, 1 need busy, 2 need busy fall, 3 need data
  int            m_cnt = 0;
  logic [NR-1:0] m_done = '0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic          m_cmd = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int            pick_w;
  logic          m_finish;

  assign pick_w   = pick(req & ~m_done, m_last);
  assign m_finish = m_active && ((m_ph == 2 && !u_busy) || (m_ph == 3 && u_data_valid));

  always @(posedge u_clk or posedge u_rst) begin
    if (u_rst) begin
      m_active <= 1'b0; m_g <= 0; m_last <= NR - 1; m_ph <= 0; m_cnt <= 0;
      m_done <= '0; m_err <= 1'b0; m_addr <= '0; m_wd <= '0; m_cmd <= 1'b0; m_rd <= '0;
    end else begin
      m_done <= '0;
      m_err  <= 1'b0;
      if (!m_active) begin
        if (!u_busy && pick_w >= 0) begin
          m_active <= 1'b1;
          m_g      <= pick_w;
          m_ph     <= 0;
          m_cnt    <= 0;
          m_addr   <= req_addr[pick_w*AW +: AW];
          m_wd     <= req_wdata[pick_w*DW +: DW];
          m_cmd    <= req_cmd[pick_w];
        end
      end else if (m_finish) begin
        m_done   <= NR'(1 << m_g);
        m_active <= 1'b0;
        m_last   <= m_g;
        if (m_ph == 3) m_rd <= u_data_o;
      end else if (TO_EN && m_cnt == TO - 1) begin
        m_done   <= NR'(1 << m_g);
        m_err    <= 1'b1;
        m_active <= 1'b0;
        m_last   <= m_g;
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_ph == 0 && u_cmd_ack) m_ph <= 1;
        if (m_ph == 1 && u_busy) m_ph <= m_cmd ? 2 : 3;
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge u_clk) begin
    #1;
    check("cyc_gnt", 32'(gnt), m_active ? (32'd1 << m_g) : 32'd0);
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_u_en", 32'(u_en), 32'(m_active));
    check("cyc_rd_data", 32'(rd_data), 32'(m_rd));
    check("cyc_err", 32'(err), 32'(m_err));
    if (m_active) begin
      check("cyc_u_addr", 32'(u_addr), 32'(m_addr));
      check("cyc_u_data_i", 32'(u_data_i), 32'(m_wd));
      check("cyc_u_cmd", 32'(u_cmd), 32'(m_cmd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge u_clk);
    #2;
  endtask

  // Plays the controller side of one transaction and checks the outcome.
  task automatic serve(input bit wr, input logic [DW-1:0] rdat, input int g,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n;
    n = 0;
    while (!u_en && n < 20) begin
      tick();
      n++;
    end
    check("en_rise", 32'(u_en), 32'd1);
    check("gnt_onehot", 32'(gnt), 32'd1 << g);
    tick();
    check("u_addr", 32'(u_addr), 32'(a));
    check("u_data_i", 32'(u_data_i), 32'(wd));
    check("u_cmd", 32'(u_cmd), 32'(wr));
    u_cmd_ack = 1'b1;
    tick();
    u_cmd_ack = 1'b0;
    u_busy = 1'b1;
    tick();
    if (wr) begin
      tick();
      u_busy = 1'b0;
      tick();
    end else begin
      u_data_o = rdat;
      u_data_valid = 1'b1;
      tick();
      u_data_valid = 1'b0;
      u_busy = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1 << g);
    check("gnt_clear", 32'(gnt), 32'd0);
    check("en_low", 32'(u_en), 32'd0);
    if (!wr) check("rd_data", 32'(rd_data), 32'(rdat));
    $display("txn: requester %0d %s done, rd_data=0x%0h", g, wr ? "write" : "read", rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_u_en", 32'(u_en), 32'd0);
    check("rst_u_addr", 32'(u_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    u_rst = 1'b0;
    tick();

    // Single write from requester 0; its fields change after the grant
    req_cmd[0] = 1'b1;
    req_addr[0*AW +: AW] = 12'h2A5;
    req_wdata[0*DW +: DW] = 8'h5C;
    req[0] = 1'b1;
    tick();
    req_addr[0*AW +: AW] = 12'h111;
    req_wdata[0*DW +: DW] = 8'h00;
    serve(1'b1, 8'h00, 0, 12'h2A5, 8'h5C);
    req = '0;
    tick();

    // Read from requester 2; its req drops mid-transaction
    req_cmd[2] = 1'b0;
    req_addr[2*AW +: AW] = 12'h0F0;
    req_wdata[2*DW +: DW] = 8'h99;
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    serve(1'b0, 8'hC3, 2, 12'h0F0, 8'h99);
    // Stray data_valid while idle is ignored
    u_data_o = 8'h77;
    u_data_valid = 1'b1;
    tick();
    u_data_valid = 1'b0;
    tick();
    check("rd_data_hold", 32'(rd_data), 32'h0C3);

    // Refresh: busy for 20 cycles blocks the grant
    u_busy = 1'b1;
    req_cmd[1] = 1'b1;
    req_addr[1*AW +: AW] = 12'h3C1;
    req_wdata[1*DW +: DW] = 8'hA7;
    req[1] = 1'b1;
    repeat (20) tick();
    check("refresh_no_gnt", 32'(gnt), 32'd0);
    u_busy = 1'b0;
    tick();
    check("refresh_gnt", 32'(gnt), 32'b0010);
    serve(1'b1, 8'h00, 1, 12'h3C1, 8'hA7);
    req = '0;
    tick();

    // Reset in the middle of a read
    req_cmd[3] = 1'b0;
    req_addr[3*AW +: AW] = 12'h7FF;
    req[3] = 1'b1;
    n = 0;
    while (!u_en && n < 20) begin tick(); n++; end
    u_cmd_ack = 1'b1; tick(); u_cmd_ack = 1'b0;
    u_busy = 1'b1; tick(); tick();
    #2 u_rst = 1'b1;
    #1;
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_u_en", 32'(u_en), 32'd0);
    check("rst_mid_u_addr", 32'(u_addr), 32'd0);
    check("rst_mid_u_cmd", 32'(u_cmd), 32'd0);
    check("rst_mid_rd_data", 32'(rd_data), 32'd0);
    $display("txn: reset during read, outputs cleared");
    u_busy = 1'b0;
    req_cmd = 4'b0101;
    req_addr = {12'h404, 12'h303, 12'h202, 12'h101};
    req_wdata = {8'h40, 8'h30, 8'h20, 8'h10};
    req = 4'b1111;
    tick(); tick();
    u_rst = 1'b0;

    // All four held: strict rotation 0,1,2,3,0
    serve(1'b1, 8'h00, 0, 12'h101, 8'h10);
    serve(1'b0, 8'h11, 1, 12'h202, 8'h20);
    serve(1'b1, 8'h00, 2, 12'h303, 8'h30);
    serve(1'b0, 8'h33, 3, 12'h404, 8'h40);
    serve(1'b1, 8'h00, 0, 12'h101, 8'h10);
    req = '0;
    tick(); tick();

    // Controller never acknowledges
    req = 4'b0010;
    n = 0;
    while (!u_en && n < 20) begin tick(); n++; end
    check("noack_en", 32'(u_en), 32'd1);
`ifdef DRAM_ARB_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("wdog_not_yet", 32'(done), 32'd0);
    check("wdog_en_still", 32'(u_en), 32'd1);
    req = '0;
    tick();
    check("wdog_done", 32'(done), 32'b0010);
    check("wdog_err", 32'(err), 32'd1);
    check("wdog_en_low", 32'(u_en), 32'd0);
    $display("txn: requester 1 aborted by watchdog");
`else
    repeat (100) tick();
    check("noack_no_done", 32'(done), 32'd0);
    check("noack_en_held", 32'(u_en), 32'd1);
    $display("txn: requester 1 still waiting after 100 cycles");
    req = '0;
    u_rst = 1'b1;
    tick();
    u_rst = 1'b0;
`endif
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
